breath_led_sequencer: RTL

- Drives one LED with a breathing pattern: brightness ramps up, holds, ramps down, holds, then repeats.
- Speed level is adjusted by single-cycle debounced key pulses (up = faster, down = slower).
- Sits between the key debouncers and the LED pin, replacing ad-hoc LED control logic.
- Contains the ramp state machine, the step prescaler and a glitch-free PWM generator.

---
 rtl/breath_pkg.sv | 21 ++
 rtl/breath_led_sequencer_pwm.sv | 49 ++++
 rtl/breath_led_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/breath_pkg.sv
// Shared types and constants for the breathing LED sequencer.
// Phase codes are visible on the phase output, so their encodings are fixed.
package breath_pkg;

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } phase_e;

  localparam int PHASE_W = 2;
  localparam int SPEED_LEVELS_DEF = 8;
  localparam int SPEED_W = $clog2(SPEED_LEVELS_DEF);

  // Width helper that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/breath_led_sequencer_pwm.sv
// PWM generator: free-running counter, duty latched at period end,
// registered compare so the pin never glitches mid-period.
module breath_pwm
  import breath_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PWM_BITS-1:0] level_map,
  output logic [PWM_BITS-1:0] duty,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] cnt_d;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_d;
  logic                led_q;
  logic                led_d;

  always_comb begin
    cnt_d  = cnt_q + PWM_BITS'(1);
    duty_d = duty_q;
    led_d  = en & (cnt_q < duty_q);
    if (cnt_q == CNT_MAX) begin
      duty_d = level_map;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
      led_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      led_q  <= led_d;
    end
  end

  assign duty = duty_q;
  assign led  = led_q;

endmodule

// File: rtl/breath_led_sequencer.sv
// Breathing LED sequencer: speed register, step prescaler, ramp FSM.
// Define BREATH_GAMMA_EN for a squared (gamma) brightness map.
module breath_led_sequencer
  import breath_pkg::*;
#(
  parameter int PWM_BITS      = 8,
  parameter int SPEED_LEVELS  = 8,
  parameter int SPEED_DEFAULT = 3,
  parameter int BASE_DIV      = 1024,
  parameter int HOLD_STEPS    = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                key_up_pulse,
  input  logic                                key_down_pulse,
  output logic                                led,
  output logic [PWM_BITS-1:0]                 duty,
  output logic [clog2_min1(SPEED_LEVELS)-1:0] speed,
  output logic [PHASE_W-1:0]                  phase
);

  localparam int SPD_W  = clog2_min1(SPEED_LEVELS);
  localparam int PRE_W  = clog2_min1(BASE_DIV * SPEED_LEVELS);
  localparam int HOLD_W = clog2_min1(HOLD_STEPS + 1);

  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(SPEED_LEVELS - 1);
  localparam logic [SPD_W-1:0] SPD_RST = SPD_W'(SPEED_DEFAULT);

  logic [SPD_W-1:0]    speed_q;
  logic [SPD_W-1:0]    speed_d;
  logic [PRE_W-1:0]    presc_q;
  logic [PRE_W-1:0]    presc_d;
  phase_e              phase_q;
  phase_e              phase_d;
  logic [PWM_BITS-1:0] lvl_q;
  logic [PWM_BITS-1:0] lvl_d;
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   hold_d;

  logic                up_ok;
  logic                dn_ok;
  logic                spd_chg;
  logic [31:0]         div_m1;
  logic                step_tick;
  logic                hold_done;
  logic [PWM_BITS-1:0] level_map;

  assign up_ok = key_up_pulse & ~key_down_pulse
               & (speed_q != SPD_MAX);
  assign dn_ok = key_down_pulse & ~key_up_pulse
               & (speed_q != '0);
  assign spd_chg = up_ok | dn_ok;

  always_comb begin
    speed_d = speed_q;
    unique case (1'b1)
      up_ok:   speed_d = speed_q + SPD_W'(1);
      dn_ok:   speed_d = speed_q - SPD_W'(1);
      default: speed_d = speed_q;
    endcase
  end

  // Slower levels stretch the step period linearly.
  always_comb begin
    div_m1 = 32'(BASE_DIV)
           * (32'(SPEED_LEVELS) - 32'(speed_q))
           - 32'd1;
    step_tick = en & ~spd_chg
              & (32'(presc_q) == div_m1);
  end

  always_comb begin
    presc_d = presc_q;
    if (spd_chg || step_tick) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = presc_q + PRE_W'(1);
    end
  end

  assign hold_done =
    (32'(hold_q) + 32'd1) >= 32'(HOLD_STEPS);

  always_comb begin
    phase_d = phase_q;
    lvl_d   = lvl_q;
    hold_d  = hold_q;
    if (step_tick) begin
      unique case (phase_q)
        RISE: begin
          if (lvl_q != LVL_MAX) begin
            lvl_d = lvl_q + PWM_BITS'(1);
          end
          if (lvl_q >= LVL_MAX - PWM_BITS'(1)) begin
            phase_d = HOLD_HI;
            hold_d  = '0;
          end
        end
        HOLD_HI: begin
          if (hold_done) begin
            phase_d = FALL;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        FALL: begin
          if (lvl_q != '0) begin
            lvl_d = lvl_q - PWM_BITS'(1);
          end
          if (lvl_q <= PWM_BITS'(1)) begin
            phase_d = HOLD_LO;
            hold_d  = '0;
          end
        end
        HOLD_LO: begin
          if (hold_done) begin
            phase_d = RISE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        default: begin
          phase_d = RISE;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      speed_q <= SPD_RST;
      presc_q <= '0;
      phase_q <= RISE;
      lvl_q   <= '0;
      hold_q  <= '0;
    end else begin
      speed_q <= speed_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      lvl_q   <= lvl_d;
      hold_q  <= hold_d;
    end
  end

`ifdef BREATH_GAMMA_EN
  logic [2*PWM_BITS-1:0] lvl_sq;

  always_comb begin
    lvl_sq    = lvl_q * lvl_q;
    level_map = lvl_sq[2*PWM_BITS-1:PWM_BITS];
  end
`else
  assign level_map = lvl_q;
`endif

  breath_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .level_map (level_map),
    .duty      (duty),
    .led       (led)
  );

  assign speed = speed_q;
  assign phase = phase_q;

endmodule
